// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges the ALU and load-unit result streams onto one registered
// common data bus. Each source feeds a private FIFO; a round-robin arbiter pops
// at most one head per cycle onto cdb_flag/cdb_rob_id/cdb_val.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low holds every register
//   jump_wrong        mispredict flush (empties both FIFOs, drops same-cycle inputs)
//   ex_* / ld_*       result valid, ROB tag, 32-bit value from ALU / load unit
//   ex_nex_ava        ALU may present a result next cycle (combinational)
//   ld_nex_ava        load unit may present a result next cycle (combinational)
//   cdb_flag/rob_id/val  registered broadcast
//   ovf_err           sticky: a push hit a full FIFO with no same-cycle pop
module cdb_arbiter #(
  parameter int unsigned ROB_BW = 4,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned QBW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_wrong,
  input  logic              ex_flag,
  input  logic [ROB_BW-1:0] ex_rob_id,
  input  logic [31:0]       ex_val,
  input  logic              ld_flag,
  input  logic [ROB_BW-1:0] ld_rob_id,
  input  logic [31:0]       ld_val,
  output logic              ex_nex_ava,
  output logic              ld_nex_ava,
  output logic              cdb_flag,
  output logic [ROB_BW-1:0] cdb_rob_id,
  output logic [31:0]       cdb_val,
  output logic              ovf_err
);

  localparam int unsigned NSRC = 2;
  localparam int unsigned CW   = QBW + 1;
  localparam int unsigned DW   = 32;
  localparam logic SRC_EX = 1'b0;
  localparam logic SRC_LD = 1'b1;

  typedef struct packed {
    logic [ROB_BW-1:0] rob_id;
    logic [DW-1:0]     val;
  } cdb_entry_t;

  logic            flush;
  logic            active;
  logic [NSRC-1:0] push_req;
  logic [NSRC-1:0] push_ok;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] nonempty;
  logic [NSRC-1:0] ovf_hit;
  logic [NSRC-1:0] nex_ava;
  cdb_entry_t      in_entry [NSRC];
  cdb_entry_t      head     [NSRC];
  cdb_entry_t      head_sel;
  logic            grant_vld;
  logic            grant_src;
  logic            rr_last;

  assign flush  = rst | jump_wrong;
  assign active = rdy & ~flush;

  // Tag 0 means "no dependency" and must never reach the bus.
  assign push_req    = {ld_flag & (ld_rob_id != '0), ex_flag & (ex_rob_id != '0)};
  assign in_entry[0] = '{rob_id: ex_rob_id, val: ex_val};
  assign in_entry[1] = '{rob_id: ld_rob_id, val: ld_val};

  // Grant on occupancy before this edge's push, so there is no bypass path.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_EX;
    case (nonempty)
      2'b01: begin
        grant_vld = 1'b1;
        grant_src = SRC_EX;
      end
      2'b10: begin
        grant_vld = 1'b1;
        grant_src = SRC_LD;
      end
      2'b11: begin
        grant_vld = 1'b1;
        grant_src = ~rr_last;
      end
      default: begin
        grant_vld = 1'b0;
        grant_src = SRC_EX;
      end
    endcase
  end

  // Per-source FIFO with occupancy counter and next-cycle availability.
  for (genvar g = 0; g < NSRC; g++) begin : g_src
    cdb_entry_t     mem [QDEPTH];
    logic [QBW-1:0] wr_ptr;
    logic [QBW-1:0] rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           full;

    assign full        = (count == CW'(QDEPTH));
    assign nonempty[g] = (count != '0);
    assign pop[g]      = active & grant_vld & (grant_src == 1'(g));
    // A full FIFO still accepts a push when it is popped on the same edge.
    assign push_ok[g]  = active & push_req[g] & (~full | pop[g]);
    assign ovf_hit[g]  = active & push_req[g] & full & ~pop[g];
    assign count_next  = count + CW'(push_ok[g]) - CW'(pop[g]);
    assign nex_ava[g]  = flush | (count_next <= CW'(QDEPTH - 1));
    assign head[g]     = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (rdy) begin
        if (push_ok[g]) wr_ptr <= wr_ptr + QBW'(1);
        if (pop[g])     rd_ptr <= rd_ptr + QBW'(1);
        count <= count_next;
      end
    end

    // Storage needs no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) begin
      if (push_ok[g]) mem[wr_ptr] <= in_entry[g];
    end
  end

  assign head_sel   = grant_src ? head[1] : head[0];
  assign ex_nex_ava = nex_ava[0];
  assign ld_nex_ava = nex_ava[1];

  // Broadcast register, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_flag   <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      ovf_err    <= 1'b0;
      rr_last    <= SRC_LD;
    end else if (jump_wrong) begin
      cdb_flag <= 1'b0;
      rr_last  <= SRC_LD;
    end else if (rdy) begin
      cdb_flag <= grant_vld;
      if (grant_vld) begin
        cdb_rob_id <= head_sel.rob_id;
        cdb_val    <= head_sel.val;
      end
      if (nonempty == 2'b11) rr_last <= grant_src;
      if (|ovf_hit) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-source scoreboard queues checked by a
// broadcast monitor, plus cycle-exact checks on flag, tag, backpressure and overflow.
module tb_cdb_arbiter;

  localparam int unsigned ROB_BW = 4;
  localparam int unsigned EW     = ROB_BW + 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rdy = 1'b1;
  logic              jump_wrong = 1'b0;
  logic              ex_flag = 1'b0;
  logic [ROB_BW-1:0] ex_rob_id = '0;
  logic [31:0]       ex_val = '0;
  logic              ld_flag = 1'b0;
  logic [ROB_BW-1:0] ld_rob_id = '0;
  logic [31:0]       ld_val = '0;
  logic              ex_nex_ava;
  logic              ld_nex_ava;
  logic              cdb_flag;
  logic [ROB_BW-1:0] cdb_rob_id;
  logic [31:0]       cdb_val;
  logic              ovf_err;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_BW(ROB_BW), .QDEPTH(4), .QBW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jump_wrong (jump_wrong),
    .ex_flag    (ex_flag),
    .ex_rob_id  (ex_rob_id),
    .ex_val     (ex_val),
    .ld_flag    (ld_flag),
    .ld_rob_id  (ld_rob_id),
    .ld_val     (ld_val),
    .ex_nex_ava (ex_nex_ava),
    .ld_nex_ava (ld_nex_ava),
    .cdb_flag   (cdb_flag),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .ovf_err    (ovf_err)
  );

  int vectors = 0;
  int errors  = 0;

  logic [EW-1:0] exq [$];
  logic [EW-1:0] ldq [$];
  logic          last_active = 1'b0;
  logic [EW-1:0] mon_obs;
  logic [EW-1:0] mon_ex_head;
  logic [EW-1:0] mon_ld_head;
  logic          mon_hit;
  logic [0:7]    bp_ld_ava_exp;

  // An edge that can launch a new broadcast: enabled and not reset/flushed.
  always @(posedge clk) last_active <= rdy && !rst && !jump_wrong;

  // Every fresh broadcast must be the oldest outstanding entry of one source.
  always @(negedge clk) begin
    if (last_active && cdb_flag) begin
      vectors++;
      mon_obs     = {cdb_rob_id, cdb_val};
      mon_ex_head = (exq.size() > 0) ? exq[0] : '0;
      mon_ld_head = (ldq.size() > 0) ? ldq[0] : '0;
      mon_hit     = 1'b0;
      if (exq.size() > 0 && mon_ex_head === mon_obs) begin
        void'(exq.pop_front());
        mon_hit = 1'b1;
      end else if (ldq.size() > 0 && mon_ld_head === mon_obs) begin
        void'(ldq.pop_front());
        mon_hit = 1'b1;
      end
      assert (mon_hit) else begin
        errors++;
        $error("FAIL cdb_broadcast observed=%0h expected ex_head=%0h or ld_head=%0h",
               mon_obs, mon_ex_head, mon_ld_head);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ef, input logic [ROB_BW-1:0] et, input logic [31:0] ev,
                       input logic lf, input logic [ROB_BW-1:0] lt, input logic [31:0] lv);
    ex_flag   = ef;
    ex_rob_id = et;
    ex_val    = ev;
    ld_flag   = lf;
    ld_rob_id = lt;
    ld_val    = lv;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_bcast(input string tag, input logic [ROB_BW-1:0] t, input logic [31:0] v);
    chk({tag, "_flag"}, EW'(cdb_flag), EW'(1));
    chk({tag, "_tag"}, EW'(cdb_rob_id), EW'(t));
    chk({tag, "_val"}, EW'(cdb_val), EW'(v));
  endtask

  initial begin
    // Reset state
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_flag", EW'(cdb_flag), EW'(0));
    chk("rst_ovf", EW'(ovf_err), EW'(0));
    chk("rst_ex_ava", EW'(ex_nex_ava), EW'(1));
    chk("rst_ld_ava", EW'(ld_nex_ava), EW'(1));
    chk("rst_tag", EW'(cdb_rob_id), EW'(0));
    chk("rst_val", EW'(cdb_val), EW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_flag", EW'(cdb_flag), EW'(0));
    end

    // Single source: broadcast in cycle 2 only
    drive(1'b1, 4'd3, 32'h11, 1'b0, '0, '0);
    exq.push_back({4'd3, 32'h11});
    tick();
    idle();
    chk("single_c1_flag", EW'(cdb_flag), EW'(0));
    tick();
    chk_bcast("single_c2", 4'd3, 32'h11);
    tick();
    chk("single_c3_flag", EW'(cdb_flag), EW'(0));

    // Simultaneous push after reset: EX first since rr_last resets to LD
    do_reset();
    drive(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
    exq.push_back({4'd1, 32'hA});
    ldq.push_back({4'd2, 32'hB});
    tick();
    idle();
    chk("sim_c1_flag", EW'(cdb_flag), EW'(0));
    tick();
    chk_bcast("sim_c2", 4'd1, 32'hA);
    tick();
    chk_bcast("sim_c3", 4'd2, 32'hB);
    tick();
    chk("sim_c4_flag", EW'(cdb_flag), EW'(0));

    // Backpressure: ld fills to 4, full+pop accepts, full without pop overflows
    do_reset();
    bp_ld_ava_exp = 8'b1111_1000;
    for (int i = 0; i < 8; i++) begin
      if (i <= 5) begin
        ex_flag   = 1'b1;
        ex_rob_id = ROB_BW'(1 + i);
        ex_val    = 32'h100 + 32'(i);
        exq.push_back({ex_rob_id, ex_val});
      end else begin
        ex_flag   = 1'b0;
        ex_rob_id = '0;
        ex_val    = '0;
      end
      ld_flag = 1'b1;
      if (i <= 6) begin
        ld_rob_id = ROB_BW'(8 + i);
        ld_val    = 32'h200 + 32'(i);
        ldq.push_back({ld_rob_id, ld_val});
      end else begin
        ld_rob_id = 4'd15;
        ld_val    = 32'hDEAD;
      end
      #1;
      chk("bp_ld_ava", EW'(ld_nex_ava), EW'(bp_ld_ava_exp[i]));
      chk("bp_ex_ava", EW'(ex_nex_ava), EW'(1));
      chk("bp_ovf_clear", EW'(ovf_err), EW'(0));
      tick();
    end
    idle();
    chk("bp_ovf_set", EW'(ovf_err), EW'(1));
    for (int i = 0; i < 10; i++) tick();
    chk("bp_drained_ld_ava", EW'(ld_nex_ava), EW'(1));
    chk("bp_ovf_sticky", EW'(ovf_err), EW'(1));

    // Flush with three entries queued and a same-cycle push
    do_reset();
    chk("flush_rst_ovf", EW'(ovf_err), EW'(0));
    drive(1'b1, 4'd4, 32'h400, 1'b1, 4'd9, 32'h900);
    exq.push_back({4'd4, 32'h400});
    tick();
    drive(1'b1, 4'd5, 32'h500, 1'b1, 4'd10, 32'hA00);
    tick();
    chk_bcast("flush_pre", 4'd4, 32'h400);
    drive(1'b1, 4'd6, 32'h600, 1'b0, '0, '0);
    jump_wrong = 1'b1;
    #1;
    chk("flush_ex_ava", EW'(ex_nex_ava), EW'(1));
    chk("flush_ld_ava", EW'(ld_nex_ava), EW'(1));
    tick();
    jump_wrong = 1'b0;
    idle();
    chk("flush_flag", EW'(cdb_flag), EW'(0));
    chk("flush_tag_hold", EW'(cdb_rob_id), EW'(4));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_empty_flag", EW'(cdb_flag), EW'(0));
    end

    // Stall mid-drain and tag-0 pushes
    drive(1'b1, 4'd1, 32'h10, 1'b1, 4'd8, 32'h80);
    exq.push_back({4'd1, 32'h10});
    ldq.push_back({4'd8, 32'h80});
    tick();
    drive(1'b1, 4'd2, 32'h20, 1'b1, 4'd9, 32'h90);
    exq.push_back({4'd2, 32'h20});
    ldq.push_back({4'd9, 32'h90});
    tick();
    idle();
    chk_bcast("stall_c2", 4'd1, 32'h10);
    tick();
    rdy = 1'b0;
    drive(1'b1, 4'd0, 32'h77, 1'b0, '0, '0);
    chk_bcast("stall_c3", 4'd8, 32'h80);
    tick();
    drive(1'b1, 4'd5, 32'h55, 1'b0, '0, '0);
    chk_bcast("stall_c4", 4'd8, 32'h80);
    tick();
    rdy = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 4'd0, 32'h99);
    chk_bcast("stall_c5", 4'd8, 32'h80);
    tick();
    idle();
    chk_bcast("stall_c6", 4'd2, 32'h20);
    tick();
    chk_bcast("stall_c7", 4'd9, 32'h90);
    tick();
    chk("stall_c8_flag", EW'(cdb_flag), EW'(0));
    for (int i = 0; i < 4; i++) tick();

    chk("sb_ex_empty", EW'(exq.size()), EW'(0));
    chk("sb_ld_empty", EW'(ldq.size()), EW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
